// File: rtl/fx_div_seq_pkg.sv
// fx_div_seq_pkg
//   Shared definitions for the fixed-point arithmetic blocks: default Q-format,
//   the divider FSM state type, and magnitude/saturation helpers.
//   The helpers work on 64-bit containers. Callers cast to and from their own
//   width, so they are valid for any format with WIDTH + FRAC_BITS <= 64.
package fx_div_seq_pkg;

  localparam int FX_WIDTH = 32;
  localparam int FX_FRAC  = 21;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } fx_div_state_t;

  // Largest positive value of a width-bit two's complement number.
  function automatic logic [63:0] fx_max(input int width);
    logic [63:0] one;
    one = 64'd1;
    return (one << (width - 32'sd1)) - 64'd1;
  endfunction

  // Bit pattern of the most negative width-bit value, which is also its magnitude.
  function automatic logic [63:0] fx_min(input int width);
    logic [63:0] one;
    one = 64'd1;
    return one << (width - 32'sd1);
  endfunction

  // Magnitude of a sign-extended value. The most negative width-bit value maps
  // to 2^(width-1), which still fits in width unsigned bits.
  function automatic logic [63:0] fx_abs(input logic [63:0] v);
    logic [63:0] r;
    if (v[63]) begin
      r = ~v + 64'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Overflow flag for a magnitude that will be given sign neg in width bits.
  function automatic logic fx_sat_ovf(input logic [63:0] mag, input logic neg, input int width);
    logic r;
    if (neg) begin
      r = (mag > fx_min(width));
    end else begin
      r = (mag > fx_max(width));
    end
    return r;
  endfunction

  // Signed result for a magnitude and sign, clamped to the width-bit range.
  // The caller keeps only the low width bits.
  function automatic logic [63:0] fx_sat_val(input logic [63:0] mag, input logic neg, input int width);
    logic [63:0] r;
    if (neg) begin
      if (mag > fx_min(width)) begin
        r = fx_min(width);
      end else begin
        r = ~mag + 64'd1;
      end
    end else begin
      if (mag > fx_max(width)) begin
        r = fx_max(width);
      end else begin
        r = mag;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fx_div_seq_if.sv
// fx_div_seq_if
//   Operand/result handshake bundle for the sequential fixed-point divider.
//   master : the producer/consumer. It drives the operands and out_ready.
//   slave  : the divider. It drives in_ready, the result and the flags.
interface fx_div_seq_if
  import fx_div_seq_pkg::*;
#(
  parameter int WIDTH = FX_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] numerator;
  logic [WIDTH-1:0] denominator;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output in_valid, numerator, denominator, out_ready,
    input  in_ready, out_valid, result, div_by_zero, overflow
  );

  modport slave (
    input  in_valid, numerator, denominator, out_ready,
    output in_ready, out_valid, result, div_by_zero, overflow
  );

endinterface

// File: rtl/fx_div_seq_step.sv
// fx_div_seq_step
//   One combinational restoring-division iteration.
//   rem_in  : partial remainder (always < divisor, so bit WIDTH is 0 on entry)
//   bit_in  : next dividend bit, shifted into the remainder LSB
//   divisor : unsigned divisor magnitude
//   rem_out : updated remainder
//   q_bit   : quotient bit produced by this step
module fx_div_seq_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] trial_s;
  logic [WIDTH+1:0] diff_s;

  assign trial_s = {rem_in, bit_in};
  assign diff_s  = trial_s - {2'b00, divisor};

  // Subtract the divisor when it fits, otherwise keep the shifted remainder.
  always_comb begin
    rem_out = (WIDTH+1)'(trial_s);
    q_bit   = 1'b0;
    if (trial_s >= {2'b00, divisor}) begin
      rem_out = (WIDTH+1)'(diff_s);
      q_bit   = 1'b1;
    end else begin
      rem_out = (WIDTH+1)'(trial_s);
      q_bit   = 1'b0;
    end
  end

endmodule

// File: rtl/fx_div_seq.sv
// fx_div_seq
//   Sequential signed fixed-point divider (Q(WIDTH-FRAC_BITS).FRAC_BITS) using
//   radix-2 restoring division on magnitudes. The quotient truncates toward zero
//   and saturates on overflow. A zero divisor returns a saturated result with
//   div_by_zero set.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : slave side of fx_div_seq_if. The inputs are in_valid, numerator,
//          denominator and out_ready. The outputs are in_ready, out_valid,
//          result, div_by_zero and overflow, all registered.
//   Requires WIDTH + FRAC_BITS <= 64 and FRAC_BITS >= 1.
module fx_div_seq
  import fx_div_seq_pkg::*;
#(
  parameter int WIDTH     = FX_WIDTH,
  parameter int FRAC_BITS = FX_FRAC
) (
  input logic          clk,
  input logic          rst,
  fx_div_seq_if.slave  bus
);

  localparam int N  = WIDTH + FRAC_BITS;
  localparam int CW = $clog2(N);

  localparam logic [WIDTH-1:0] FX_MAX   = WIDTH'(fx_max(WIDTH));
  localparam logic [WIDTH-1:0] FX_MIN   = WIDTH'(fx_min(WIDTH));
  localparam logic [CW-1:0]    CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  fx_div_state_t    state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [N-1:0]     dividend_q, dividend_d;
  logic [N-1:0]     quot_q, quot_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic             sign_q, sign_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] n_abs_s;
  logic [WIDTH-1:0] d_abs_s;
  logic [WIDTH:0]   step_rem_s;
  logic             step_q_s;

  // Magnitudes are taken on sign-extended copies so that FX_MIN maps to 2^(WIDTH-1).
  assign n_abs_s = WIDTH'(fx_abs(64'(signed'(bus.numerator))));
  assign d_abs_s = WIDTH'(fx_abs(64'(signed'(bus.denominator))));

  fx_div_seq_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in  (rem_q),
    .bit_in  (dividend_q[N-1]),
    .divisor (divisor_q),
    .rem_out (step_rem_s),
    .q_bit   (step_q_s)
  );

  // Next-state and next-output logic for the IDLE/CALC/FIN/DONE sequence.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    dividend_d  = dividend_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    divisor_d   = divisor_q;
    sign_d      = sign_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          sign_d     = bus.numerator[WIDTH-1] ^ bus.denominator[WIDTH-1];
          dividend_d = {n_abs_s, {FRAC_BITS{1'b0}}};
          divisor_d  = d_abs_s;
          rem_d      = {(WIDTH+1){1'b0}};
          quot_d     = {N{1'b0}};
          count_d    = {CW{1'b0}};
          in_ready_d = 1'b0;
          if (bus.denominator == {WIDTH{1'b0}}) begin
            // Zero divisor skips the iterations. The result saturates toward the numerator's sign.
            state_d     = DONE;
            out_valid_d = 1'b1;
            dbz_d       = 1'b1;
            ovf_d       = 1'b0;
            result_d    = bus.numerator[WIDTH-1] ? FX_MIN : FX_MAX;
          end else begin
            state_d = CALC;
            dbz_d   = 1'b0;
            ovf_d   = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        rem_d      = step_rem_s;
        quot_d     = {quot_q[N-2:0], step_q_s};
        dividend_d = {dividend_q[N-2:0], 1'b0};
        if (count_q == CNT_LAST) begin
          state_d = FIN;
          count_d = {CW{1'b0}};
        end else begin
          state_d = CALC;
          count_d = count_q + CNT_ONE;
        end
      end
      FIN: begin
        // The negative range reaches one step further than the positive range (|FX_MIN| = FX_MAX + 1).
        ovf_d       = fx_sat_ovf(64'(quot_q), sign_q, WIDTH);
        result_d    = WIDTH'(fx_sat_val(64'(quot_q), sign_q, WIDTH));
        dbz_d       = 1'b0;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        // out_valid is always high here, so out_ready alone completes the handoff.
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        count_d     = {CW{1'b0}};
      end
    endcase
  end

  // State, datapath and output registers. Reset discards any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= {CW{1'b0}};
      dividend_q  <= {N{1'b0}};
      quot_q      <= {N{1'b0}};
      rem_q       <= {(WIDTH+1){1'b0}};
      divisor_q   <= {WIDTH{1'b0}};
      sign_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= {WIDTH{1'b0}};
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      dividend_q  <= dividend_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      divisor_q   <= divisor_d;
      sign_q      <= sign_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.result      = result_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_fx_div_seq.sv
// tb_fx_div_seq
//   Bench for fx_div_seq with default Q11.21. Expected results are pushed to a
//   scoreboard queue at the accept edge and popped when out_valid is seen.
//   Latency is counted with the accept edge as edge 1.
module tb_fx_div_seq;

  typedef struct packed {
    logic [31:0] res;
    logic        dbz;
    logic        ovf;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sb[$];

  fx_div_seq_if #(.WIDTH(32)) bus ();

  fx_div_seq #(.WIDTH(32), .FRAC_BITS(21)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: 64-bit signed divide truncates toward zero. Out-of-range quotients clamp.
  function automatic exp_t model(input logic [31:0] n, input logic [31:0] d);
    exp_t   e;
    longint nn;
    longint dd;
    longint q;
    if (d == 32'd0) begin
      e.res = n[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      e.dbz = 1'b1;
      e.ovf = 1'b0;
    end else begin
      nn = longint'(signed'(n)) <<< 21;
      dd = longint'(signed'(d));
      q  = nn / dd;
      e.dbz = 1'b0;
      if (q > 64'sd2147483647) begin
        e.res = 32'h7FFF_FFFF;
        e.ovf = 1'b1;
      end else if (q < -64'sd2147483648) begin
        e.res = 32'h8000_0000;
        e.ovf = 1'b1;
      end else begin
        e.res = q[31:0];
        e.ovf = 1'b0;
      end
    end
    return e;
  endfunction

  function automatic exp_t mk(input logic [31:0] r, input logic z, input logic o);
    exp_t e;
    e.res = r;
    e.dbz = z;
    e.ovf = o;
    return e;
  endfunction

  // Runs one operation: waits for in_ready, drives one accept, checks result, flags and latency, then hands off.
  task automatic run_op(input logic [31:0] n, input logic [31:0] d, input exp_t e,
                        input int exp_lat, input string name);
    int   lat;
    int   w;
    exp_t got;
    w = 0;
    while (!bus.in_ready && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    bus.in_valid    = 1'b1;
    bus.numerator   = n;
    bus.denominator = d;
    @(posedge clk); #1;
    sb.push_back(e);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (!bus.out_valid) begin
      errors++;
      $display("FAIL %s timeout: out_valid got 0 want 1 within 200 cycles", name);
      sb.delete();
    end else begin
      got = sb.pop_front();
      checks++;
      if (bus.result !== got.res) begin
        errors++;
        $display("FAIL %s result: got %h want %h", name, bus.result, got.res);
      end
      checks++;
      if (bus.div_by_zero !== got.dbz || bus.overflow !== got.ovf) begin
        errors++;
        $display("FAIL %s flags: got dbz=%b ovf=%b want dbz=%b ovf=%b", name,
                 bus.div_by_zero, bus.overflow, got.dbz, got.ovf);
      end
      if (exp_lat > 0) begin
        checks++;
        if (lat !== exp_lat) begin
          errors++;
          $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
        end
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s handoff: got out_valid=%b in_ready=%b want 0 1", name,
                 bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset handshake: got in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
    end
    checks++;
    if (bus.result !== 32'h0 || bus.div_by_zero !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset outputs: got result=%h dbz=%b ovf=%b want 0 0 0",
               bus.result, bus.div_by_zero, bus.overflow);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    run_op(32'h0030_0000, 32'h0010_0000, mk(32'h0060_0000, 1'b0, 1'b0), 55, "pos_1p5_div_0p5");
    run_op(32'hFFD0_0000, 32'h0010_0000, mk(32'hFFA0_0000, 1'b0, 1'b0), 55, "neg_1p5_div_0p5");
    run_op(32'h0020_0000, 32'h0060_0000, mk(32'h000A_AAAA, 1'b0, 1'b0), 55, "one_third");
    run_op(32'hFFE0_0000, 32'h0060_0000, mk(32'hFFF5_5556, 1'b0, 1'b0), 55, "neg_one_third");
    run_op(32'h0000_0000, 32'hFFF0_0000, mk(32'h0000_0000, 1'b0, 1'b0), 55, "zero_num");
  endtask

  task automatic test_div_zero();
    run_op(32'h0020_0000, 32'h0000_0000, mk(32'h7FFF_FFFF, 1'b1, 1'b0), 1, "dbz_pos");
    run_op(32'hFFE0_0000, 32'h0000_0000, mk(32'h8000_0000, 1'b1, 1'b0), 1, "dbz_neg");
  endtask

  task automatic test_overflow();
    run_op(32'h7D00_0000, 32'h0000_083C, mk(32'h7FFF_FFFF, 1'b0, 1'b1), 55, "ovf_big");
    run_op(32'h8000_0000, 32'hFFE0_0000, mk(32'h7FFF_FFFF, 1'b0, 1'b1), 55, "ovf_min_neg1");
    run_op(32'h8000_0000, 32'h0020_0000, mk(32'h8000_0000, 1'b0, 1'b0), 55, "min_div_1");
  endtask

  task automatic test_random();
    logic [31:0] n;
    logic [31:0] d;
    for (int i = 0; i < 6; i++) begin
      n = $urandom() >> $urandom_range(0, 12);
      if ($urandom_range(0, 1) == 1) n = -n;
      d = $urandom() >> $urandom_range(0, 24);
      if ($urandom_range(0, 1) == 1) d = -d;
      if (d == 32'd0) d = 32'h0010_0000;
      run_op(n, d, model(n, d), 55, "random");
    end
  endtask

  task automatic test_backpressure();
    int w;
    w = 0;
    while (!bus.in_ready && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    bus.in_valid    = 1'b1;
    bus.numerator   = 32'h0030_0000;
    bus.denominator = 32'h0010_0000;
    @(posedge clk); #1;
    sb.push_back(model(32'h0030_0000, 32'h0010_0000));
    bus.in_valid = 1'b0;
    w = 0;
    while (!bus.out_valid && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    checks++;
    if (!bus.out_valid) begin
      errors++;
      $display("FAIL bp timeout: out_valid got 0 want 1");
      sb.delete();
    end else begin
      for (int c = 0; c < 20; c++) begin
        bus.in_valid    = c[0];
        bus.numerator   = 32'h0012_3456 + c;
        bus.denominator = 32'h0000_0001;
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result !== sb[0].res ||
            bus.div_by_zero !== 1'b0 || bus.overflow !== 1'b0) begin
          errors++;
          $display("FAIL bp hold cycle %0d: got ov=%b ir=%b res=%h want 1 0 %h", c,
                   bus.out_valid, bus.in_ready, bus.result, sb[0].res);
        end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      void'(sb.pop_front());
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL bp release: got out_valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
      end
      w = 0;
      for (int c = 0; c < 60; c++) begin
        @(posedge clk); #1;
        if (bus.out_valid) w++;
      end
      checks++;
      if (w != 0) begin
        errors++;
        $display("FAIL bp ignored pulses: got %0d out_valid cycles want 0", w);
      end
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    while (!bus.in_ready) begin
      @(posedge clk); #1;
    end
    bus.in_valid    = 1'b1;
    bus.numerator   = 32'h0030_0000;
    bus.denominator = 32'h0010_0000;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== 32'h0 ||
        bus.div_by_zero !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL mid reset: got ir=%b ov=%b res=%h dbz=%b ovf=%b want 1 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.result, bus.div_by_zero, bus.overflow);
    end
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 70; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL mid reset discard: got %0d out_valid cycles want 0", seen);
    end
    run_op(32'h0020_0000, 32'h0060_0000, mk(32'h000A_AAAA, 1'b0, 1'b0), 55, "after_reset");
  endtask

  task automatic test_back_to_back();
    logic [31:0] tn [4];
    logic [31:0] td [4];
    int   idx;
    int   got_n;
    int   cyc;
    int   last_acc;
    logic rdy_before;
    exp_t e;
    tn[0] = 32'h0030_0000; td[0] = 32'h0010_0000;
    tn[1] = 32'hFFE0_0000; td[1] = 32'h0060_0000;
    tn[2] = 32'h0123_4567; td[2] = 32'hFF80_0000;
    tn[3] = 32'h7D00_0000; td[3] = 32'h0000_083C;
    idx = 0; got_n = 0; cyc = 0; last_acc = -1;
    bus.out_ready   = 1'b1;
    bus.in_valid    = 1'b1;
    bus.numerator   = tn[0];
    bus.denominator = td[0];
    while (got_n < 4 && cyc < 1000) begin
      rdy_before = bus.in_ready;
      @(posedge clk); #1;
      cyc++;
      if (rdy_before && bus.in_valid) begin
        sb.push_back(model(tn[idx], td[idx]));
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc != 56) begin
            errors++;
            $display("FAIL b2b spacing: got %0d want 56", cyc - last_acc);
          end
        end
        last_acc = cyc;
        idx++;
        if (idx < 4) begin
          bus.numerator   = tn[idx];
          bus.denominator = td[idx];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      if (bus.out_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL b2b unexpected output: got res=%h want none", bus.result);
        end else begin
          e = sb.pop_front();
          if (bus.result !== e.res || bus.div_by_zero !== e.dbz || bus.overflow !== e.ovf) begin
            errors++;
            $display("FAIL b2b result %0d: got %h/%b/%b want %h/%b/%b", got_n,
                     bus.result, bus.div_by_zero, bus.overflow, e.res, e.dbz, e.ovf);
          end
        end
        got_n++;
      end
    end
    checks++;
    if (got_n != 4) begin
      errors++;
      $display("FAIL b2b timeout: got %0d results want 4", got_n);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    sb.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst             = 1'b1;
    bus.in_valid    = 1'b0;
    bus.numerator   = 32'h0;
    bus.denominator = 32'h0;
    bus.out_ready   = 1'b0;
    test_reset();
    test_basic();
    test_div_zero();
    test_overflow();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
